sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/sprite_plotter.sv | 149 ++++++++++++++
 tb/tb_sprite_plotter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - 4x4 sprite draw/erase engine feeding a vga_adapter pixel port
//
// Purpose: on a start request, latch position/sprite/colour, then emit one
// pixel per cycle over the SIZE x SIZE box in row-major order. A pixel is
// written (plot=1) only if it is on the 160x120 screen and either the request
// is an erase or the selected sprite mask bit is set. Latency is fixed.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   start      - draw request, sampled only in IDLE
//   x_in/y_in  - sprite top-left position
//   sprite_sel - 0 crosshair, 1 bird
//   erase      - 1 clears the whole box with BG_COLOUR
//   colour_in  - draw colour
//   x_out/y_out/colour_out/plot - registered pixel write to vga_adapter
//   busy       - high while a request is in progress
//   done       - one-cycle completion pulse

module sprite_plotter #(
  parameter int                     SIZE       = 4,
  parameter logic [SIZE*SIZE-1:0]   CROSS_MASK = 16'h0272,
  parameter logic [SIZE*SIZE-1:0]   BIRD_MASK  = 16'h9FF9,
  parameter logic [2:0]             BG_COLOUR  = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic       sprite_sel,
  input  logic       erase,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int NPIX = SIZE * SIZE;
  localparam int IW   = $clog2(NPIX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;

  // Request fields captured on the accepting edge; inputs are ignored afterwards.
  logic [7:0] x_lat;
  logic [6:0] y_lat;
  logic       sel_lat;
  logic       erase_lat;
  logic [2:0] colour_lat;

  // Pixel coordinates are summed one bit wider than the ports so that a sprite
  // hanging off the right/bottom edge is clipped instead of wrapping to 0.
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       on_screen;
  logic       mask_bit;
  logic       pix_plot;
  logic       last_pix;

  always_comb begin
    sum_x     = {1'b0, x_lat} + 9'(int'(idx) % SIZE);
    sum_y     = {1'b0, y_lat} + 8'(int'(idx) / SIZE);
    on_screen = (sum_x <= 9'd159) && (sum_y <= 8'd119);
    mask_bit  = sel_lat ? BIRD_MASK[idx] : CROSS_MASK[idx];
    pix_plot  = on_screen && (erase_lat || mask_bit);
    last_pix  = (idx == IW'(NPIX - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
      sel_lat    <= 1'b0;
      erase_lat  <= 1'b0;
      colour_lat <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            x_lat      <= x_in;
            y_lat      <= y_in;
            sel_lat    <= sprite_sel;
            erase_lat  <= erase;
            colour_lat <= colour_in;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end

        LOAD: begin
          plot  <= 1'b0;
          idx   <= '0;
          state <= DRAW;
        end

        // Every index takes one cycle whether or not it is written, so the
        // request always completes at the same edge.
        DRAW: begin
          x_out      <= sum_x[7:0];
          y_out      <= sum_y[6:0];
          colour_out <= erase_lat ? BG_COLOUR : colour_lat;
          plot       <= pix_plot;
          if (last_pix) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // DONE spans two cycles: the first edge raises done, the second drops
        // done and busy together and returns to IDLE, giving a 20-cycle period.
        DONE: begin
          plot <= 1'b0;
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - self-checking bench for sprite_plotter against a pixel-list model

module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic       sprite_sel;
  logic       erase;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [15:0] cross_bits = 16'h0272;
  logic [15:0] bird_bits  = 16'h9FF9;

  sprite_plotter dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .sprite_sel(sprite_sel), .erase(erase), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: random ignored start pulses and input scrambling while busy
  // mode 1: start pulsed at N+5 and N+18 only
  // mode 2: start held high throughout (back-to-back requests)
  task automatic do_request(input logic sel, input logic er, input int x, input int y,
                            input int c, input int mode, output int nplot);
    bit ep[16];
    int ex[16];
    int ey[16];
    int ec;
    int sx, sy;
    nplot = 0;
    for (int i = 0; i < 16; i++) begin
      sx = x + i % 4;
      sy = y + i / 4;
      ep[i] = (sx <= 159) && (sy <= 119) && (er || (sel ? bird_bits[i] : cross_bits[i]));
      ex[i] = sx % 256;
      ey[i] = sy % 128;
    end
    ec = er ? 0 : c;

    sprite_sel = sel; erase = er; x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    start = 1'b1;
    tick;  // edge N
    check("busy_accept", busy, 1);
    check("done_accept", done, 0);
    check("plot_accept", plot, 0);

    for (int k = 1; k <= 19; k++) begin
      if (mode == 2) start = 1'b1;
      else if (mode == 1) start = (k == 5 || k == 18);
      else start = 1'($urandom);
      x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom);
      sprite_sel = 1'($urandom); erase = 1'($urandom);
      tick;  // edge N+k
      if (plot) nplot++;
      if (k == 1) begin
        check("load_plot", plot, 0);
        check("load_busy", busy, 1);
      end else if (k <= 17) begin
        check("pix_plot", plot, ep[k-2]);
        check("pix_x", x_out, ex[k-2]);
        check("pix_y", y_out, ey[k-2]);
        check("pix_colour", colour_out, ec);
        check("draw_done", done, 0);
        check("draw_busy", busy, 1);
      end else if (k == 18) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_plot", plot, 0);
      end else begin
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_plot", plot, 0);
      end
    end
    if (mode != 2) start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b1; x_in = '0; y_in = '0;
    sprite_sel = 1'b0; erase = 1'b0; colour_in = '0;
    tick;
    check("rst_busy", busy, 0);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour_out, 0);
    reset = 1'b0; start = 1'b0;
    tick;
    check("idle_busy", busy, 0);

    do_request(1'b0, 1'b0, 10, 20, 3'b100, 0, n);
    check("cross_count", n, 5);
    do_request(1'b1, 1'b1, 50, 50, 3'b111, 0, n);
    check("erase_count", n, 16);
    do_request(1'b1, 1'b1, 158, 118, 3'b010, 0, n);
    check("clip_count", n, 4);
    do_request(1'b0, 1'b0, 30, 30, 3'b001, 1, n);
    check("ignore_count", n, 5);
    tick;
    check("ignore_idle", busy, 0);

    // Held start: each call's first check confirms acceptance on the first IDLE edge.
    do_request(1'b1, 1'b0, 5, 5, 3'b011, 2, n);
    do_request(1'b0, 1'b0, 100, 60, 3'b110, 2, n);
    do_request(1'b1, 1'b1, 157, 117, 3'b101, 2, n);
    start = 1'b0;
    tick;
    check("held_release", busy, 0);

    for (int r = 0; r < 20; r++) begin
      do_request(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 0, n);
      if ($urandom_range(0, 1) == 1) tick;
    end

    // Reset in the middle of a bird draw.
    sprite_sel = 1'b1; erase = 1'b0; x_in = 8'd30; y_in = 7'd40; colour_in = 3'd5;
    start = 1'b1;
    tick;  // edge N
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick;
    reset = 1'b1;
    tick;  // edge N+8
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_x", x_out, 0);
    check("midrst_colour", colour_out, 0);
    reset = 1'b0;
    n = 0;
    begin
      int dn = 0;
      for (int k = 0; k < 20; k++) begin
        tick;
        if (plot) n++;
        if (done) dn++;
      end
      check("midrst_no_plot", n, 0);
      check("midrst_no_done", dn, 0);
      check("midrst_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
